// File: rtl/instr_mem_loader_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_if
//   Bundles the loader byte stream, fetch port and status outputs of
//   instr_mem_loader.
//   master : drives clear/load pulses, byte stream and fetch request,
//            observes status and the fetched word.
//   slave  : the memory/loader itself.
//   Signals:
//     i_clear, i_load_start     command pulses
//     i_byte_valid, i_byte      loader byte stream, o_byte_ready back-pressure
//     i_fetch_en, i_fetch_addr  fetch request, o_instruction registered word
//     o_busy, o_load_done       state flags
//     o_overflow, o_word_count  load result
// ---------------------------------------------------------------------------
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
);
   logic                  i_clear;
   logic                  i_load_start;
   logic                  i_byte_valid;
   logic [7:0]            i_byte;
   logic                  o_byte_ready;
   logic                  i_fetch_en;
   logic [ADDR_WIDTH-1:0] i_fetch_addr;
   logic [DATA_WIDTH-1:0] o_instruction;
   logic                  o_busy;
   logic                  o_load_done;
   logic                  o_overflow;
   logic [ADDR_WIDTH:0]   o_word_count;

   modport master (
      output i_clear, i_load_start, i_byte_valid, i_byte, i_fetch_en, i_fetch_addr,
      input  o_byte_ready, o_instruction, o_busy, o_load_done, o_overflow, o_word_count
   );

   modport slave (
      input  i_clear, i_load_start, i_byte_valid, i_byte, i_fetch_en, i_fetch_addr,
      output o_byte_ready, o_instruction, o_busy, o_load_done, o_overflow, o_word_count
   );
endinterface

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Instruction memory for the IF stage with a built-in program loader.
//   A byte stream is packed little-endian into DATA_WIDTH words that are
//   written sequentially from address 0. A load stops on an all-ones (HALT)
//   word, which is itself stored, or when the last address has been written.
//   A clear sweep writes zero to every word, one word per cycle.
//   The fetch port is a 1-cycle registered read; it can be stalled and
//   returns 0 (NOP) while the memory is being cleared or loaded.
// Ports:
//   i_clk    clock
//   i_reset  synchronous, active-high reset (memory contents are kept)
//   bus      instr_mem_loader_if.slave: commands, byte stream, fetch, status
// ---------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32
) (
   input  logic               i_clk,
   input  logic               i_reset,
   instr_mem_loader_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(BYTES - 1);

   generate
      if (DATA_WIDTH % 8 != 0) begin : g_bad_width
         $error("instr_mem_loader: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DONE
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] clr_ptr;
   logic [ADDR_WIDTH-1:0] word_ptr;
   logic [IDX_W-1:0]      byte_idx;
   logic [DATA_WIDTH-1:0] part_word;

   logic                  byte_ready_q;
   logic                  busy_q;
   logic                  load_done_q;
   logic                  overflow_q;
   logic [ADDR_WIDTH:0]   word_count_q;
   logic [DATA_WIDTH-1:0] instr_q;

   logic                  take;
   logic                  word_done;
   logic                  is_halt;
   logic [DATA_WIDTH-1:0] full_word;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // byte_ready_q is only ever high in LOAD, so it doubles as the state qualifier
   assign take      = bus.i_byte_valid & byte_ready_q;
   assign word_done = take & (byte_idx == LAST_IDX);
   assign is_halt   = &full_word;

   // Partial word with the incoming byte dropped into its lane; on the last
   // byte this is the complete word that gets written this cycle.
   always_comb begin
      full_word = part_word;
      for (int b = 0; b < BYTES; b++) begin
         if (byte_idx == IDX_W'(b)) full_word[8*b +: 8] = bus.i_byte;
      end
   end

   // Single write port: CLEAR and LOAD are exclusive states, so the two
   // sources never collide. Writes are suppressed in a reset cycle so an
   // aborted load leaves memory exactly as it was.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = word_ptr;
      mem_wdata = full_word;
      if (!i_reset) begin
         if (state == S_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
         end else if (word_done) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Registered fetch. Nonblocking semantics make a same-cycle read of the
   // address being written return the old contents.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         instr_q <= '0;
      end else if (state == S_CLEAR || state == S_LOAD) begin
         instr_q <= '0;
      end else if (bus.i_fetch_en) begin
         instr_q <= mem[bus.i_fetch_addr];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= S_IDLE;
         clr_ptr      <= '0;
         word_ptr     <= '0;
         byte_idx     <= '0;
         part_word    <= '0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         load_done_q  <= 1'b0;
         overflow_q   <= 1'b0;
         word_count_q <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               // clear has priority over a simultaneous load request
               if (bus.i_clear) begin
                  state        <= S_CLEAR;
                  clr_ptr      <= '0;
                  busy_q       <= 1'b1;
                  load_done_q  <= 1'b0;
                  byte_ready_q <= 1'b0;
               end else if (bus.i_load_start) begin
                  state        <= S_LOAD;
                  word_ptr     <= '0;
                  byte_idx     <= '0;
                  part_word    <= '0;
                  word_count_q <= '0;
                  overflow_q   <= 1'b0;
                  load_done_q  <= 1'b0;
                  busy_q       <= 1'b1;
                  byte_ready_q <= 1'b1;
               end
            end

            S_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_ADDR) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            end

            S_LOAD: begin
               if (take) begin
                  if (byte_idx == LAST_IDX) begin
                     byte_idx     <= '0;
                     part_word    <= '0;
                     word_ptr     <= word_ptr + 1'b1;
                     word_count_q <= word_count_q + 1'b1;
                     // HALT is tested first so a HALT in the last slot is not an overflow
                     if (is_halt || word_ptr == LAST_ADDR) begin
                        state        <= S_DONE;
                        busy_q       <= 1'b0;
                        byte_ready_q <= 1'b0;
                        load_done_q  <= 1'b1;
                        overflow_q   <= ~is_halt;
                     end
                  end else begin
                     part_word <= full_word;
                     byte_idx  <= byte_idx + 1'b1;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_byte_ready  = byte_ready_q;
   assign bus.o_busy        = busy_q;
   assign bus.o_load_done   = load_done_q;
   assign bus.o_overflow    = overflow_q;
   assign bus.o_word_count  = word_count_q;
   assign bus.o_instruction = instr_q;
endmodule
